alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Sits between the instruction decoder and the 6502 ALU datapath, and owns the ALU's `a`, `b`, `func` and carry inputs.
- Accepts one arithmetic/logic operation per valid/ready handshake and maps it onto the ALU's SUM/AND/OR/XOR functions, including operand inversion for SBC/CMP.
- Forces a func change between operations so that the ALU's `wout` strobe is never stale.
- Waits for `wout` with a timeout, then returns the result, C/Z/N/V flags and a flag-write mask to the decoder.

Parameters:
REG_WIDTH, 8, datapath width (matches `REG_WIDTH).
OPP_WIDTH, 4, ALU func width (matches `OPP_WIDTH).
TIMEOUT, 8, maximum WAIT cycles before the operation is aborted with an error.

Ports:
phi1  input  1  clock; all state updates on posedge phi1.
reset_n  input  1  asynchronous, active-low reset.
op_valid  input  1  decoder presents an operation.
op_ready  output  1  sequencer can accept; high only in IDLE.
op_code  input  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 ASL, 7 INC, 8 DEC; 9-15 illegal.
op_a  input  REG_WIDTH  accumulator/memory operand A.
op_b  input  REG_WIDTH  operand B (ignored by ASL/INC/DEC).
carry_in  input  1  current processor C flag.
alu_a  output  REG_WIDTH  ALU a input.
alu_b  output  REG_WIDTH  ALU b input.
alu_func  output  OPP_WIDTH  ALU func; NOP = all ones.
alu_cin  output  1  ALU carry input.
alu_dout  input  REG_WIDTH  ALU result.
alu_cout  input  1  ALU carry-out (status bit `CARRY).
alu_wout  input  1  ALU result-valid strobe.
res_valid  output  1  result/flags valid; held until accepted.
res_ready  input  1  decoder accepts the result.
result  output  REG_WIDTH  operation result.
flags  output  4  {V,N,Z,C}.
flag_we  output  4  {V,N,Z,C} write mask.
err  output  1  illegal opcode or timeout; qualified by res_valid.

Behaviour:
- Reset (asynchronous, immediate):
  - state goes to IDLE; alu_func = NOP.
  - alu_a, alu_b, alu_cin, result, flags, flag_we, err, res_valid and the timeout counter all clear to 0.
  - op_ready = 1 once reset_n is high.
  - Reset in any state aborts the operation with no result.
- States: IDLE -> FLUSH -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: on op_valid&&op_ready, latch op_code/op_a/op_b/carry_in.
  - Legal opcode: go to FLUSH.
  - Illegal opcode: go to DONE with err=1, result=0, flag_we=0; the ALU is never touched.
- FLUSH (1 cycle): alu_func = NOP, so the ALU sees a func change and drops wout.
- ISSUE (1 cycle): drive the mapped alu_func/alu_a/alu_b/alu_cin. These are held unchanged through WAIT; alu_func returns to NOP on entering DONE.
- WAIT: each cycle, if alu_wout==1, capture the result and go to DONE.
  - Otherwise increment the counter; when counter==TIMEOUT-1 and still no wout, go to DONE with err=1, result=0, flag_we=0.
- DONE: res_valid=1; outputs are stable until res_valid&&res_ready, then go to IDLE and clear res_valid. op_valid is not accepted in DONE (one-cycle bubble).
- Minimum latency: accept at edge N, res_valid high after edge N+3.
- Operation mapping (alu_func / alu_a / alu_b / alu_cin):
  - ADC: SUM / A / B / carry_in.
  - SBC: SUM / A / ~B / carry_in.
  - CMP: SUM / A / ~B / 1.
  - AND, ORA, EOR: AND, OR, XOR / A / B / 0.
  - ASL: SUM / A / A / 0.
  - INC: SUM / A / 0x00 / 1.
  - DEC: SUM / A / 0xFF / 0.
- Flags:
  - Z = (result==0); N = result[REG_WIDTH-1]; C = alu_cout.
  - V = (alu_a[msb]==alu_b[msb]) && (alu_dout[msb]!=alu_a[msb]).
  - CMP: Z/N/C are computed from alu_dout, but result = latched A.
- flag_we {V,N,Z,C}:
  - ADC/SBC: 1111.
  - CMP/ASL: 0111.
  - AND/ORA/EOR/INC/DEC: 0110.
  - Unwritten flag bits are driven 0.
- Back-to-back operations with the same func are always separated by FLUSH, so a stale wout from the previous operation is never captured.

Test Plan:
- ADC A=0x50 B=0x50 cin=0 -> result 0xA0, flags {V,N,Z,C}=1100, flag_we 1111, err 0, res_valid exactly 3 edges after accept.
- SBC A=0x50 B=0xF0 cin=1 -> alu_b=0x0F, alu_cin=1 observed during ISSUE/WAIT; result 0x60, flags 0000, flag_we 1111.
- AND 0xF0,0x0F then immediately AND 0xFF,0x3C -> first result 0x00 (Z=1), second 0x3C; alu_func=NOP for one cycle between them, and the second result is not captured early.
- CMP 0x10,0x10 -> result 0x10, flags 0011 (Z=1,C=1), flag_we 0111; DEC 0x00 -> 0xFF, N=1, flag_we 0110.
- Hold alu_wout=0, issue ADC -> res_valid after TIMEOUT WAIT cycles with err=1, result 0x00, flag_we 0000; op_code 0xC -> err=1, res_valid 1 edge after accept, alu_func stays NOP.
- Assert reset_n=0 mid-WAIT with res_ready=0 -> res_valid, alu_func=NOP and op_ready behave per reset immediately (no clock); next ADC 0x01+0x01 completes with result 0x02.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one arithmetic/logic operation at a time onto the 6502 ALU datapath.
//
// Accepts an operation from the decoder over a valid/ready handshake. It maps the operation
// onto the ALU SUM/AND/OR/XOR functions and forces a NOP cycle (FLUSH) before every issue so
// the ALU result strobe is never stale. It then waits for alu_wout (bounded by TIMEOUT) and
// returns result, {V,N,Z,C} flags and a flag-write mask.
//
// Ports:
//   phi1, reset_n                 clock (posedge) and asynchronous active-low reset
//   op_valid/op_ready             operation handshake (ready only in IDLE)
//   op_code, op_a, op_b, carry_in operation request
//   alu_a/alu_b/alu_func/alu_cin  ALU operand/function drive (func NOP = all ones)
//   alu_dout/alu_cout/alu_wout    ALU result, carry-out and result-valid strobe
//   res_valid/res_ready           result handshake (held until accepted)
//   result, flags, flag_we, err   result, {V,N,Z,C} flags and write mask, error indication
//
// ALU func encoding: SUM = 0, AND = 1, OR = 2, XOR = 3, NOP = all ones.

module alu_sequencer #(
    parameter int unsigned REG_WIDTH = 8,
    parameter int unsigned OPP_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                 phi1,
    input  logic                 reset_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [3:0]           op_code,
    input  logic [REG_WIDTH-1:0] op_a,
    input  logic [REG_WIDTH-1:0] op_b,
    input  logic                 carry_in,
    output logic [REG_WIDTH-1:0] alu_a,
    output logic [REG_WIDTH-1:0] alu_b,
    output logic [OPP_WIDTH-1:0] alu_func,
    output logic                 alu_cin,
    input  logic [REG_WIDTH-1:0] alu_dout,
    input  logic                 alu_cout,
    input  logic                 alu_wout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic [3:0]           flags,
    output logic [3:0]           flag_we,
    output logic                 err
);

    localparam int unsigned Msb  = REG_WIDTH - 1;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [OPP_WIDTH-1:0] FuncSum = OPP_WIDTH'(0);
    localparam logic [OPP_WIDTH-1:0] FuncAnd = OPP_WIDTH'(1);
    localparam logic [OPP_WIDTH-1:0] FuncOr  = OPP_WIDTH'(2);
    localparam logic [OPP_WIDTH-1:0] FuncXor = OPP_WIDTH'(3);
    localparam logic [OPP_WIDTH-1:0] FuncNop = '1;

    localparam logic [3:0] OpAdc = 4'd0;
    localparam logic [3:0] OpSbc = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOra = 4'd3;
    localparam logic [3:0] OpEor = 4'd4;
    localparam logic [3:0] OpCmp = 4'd5;
    localparam logic [3:0] OpAsl = 4'd6;
    localparam logic [3:0] OpInc = 4'd7;
    localparam logic [3:0] OpDec = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [3:0]           opc_q, opc_d;
    logic [REG_WIDTH-1:0] a_q, a_d;
    logic [REG_WIDTH-1:0] b_q, b_d;
    logic                 cin_q, cin_d;
    logic [REG_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [REG_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPP_WIDTH-1:0] alu_func_q, alu_func_d;
    logic                 alu_cin_q, alu_cin_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] result_q, result_d;
    logic [3:0]           flags_q, flags_d;
    logic [3:0]           flag_we_q, flag_we_d;
    logic                 err_q, err_d;

    // Operation mapping, decoded from the latched opcode.
    logic [OPP_WIDTH-1:0] map_func;
    logic [REG_WIDTH-1:0] map_b;
    logic                 map_cin;
    logic [3:0]           map_we;

    always_comb begin
        map_func = FuncNop;
        map_b    = b_q;
        map_cin  = 1'b0;
        map_we   = 4'b0000;
        case (opc_q)
            OpAdc: begin map_func = FuncSum; map_b = b_q;  map_cin = cin_q; map_we = 4'b1111; end
            OpSbc: begin map_func = FuncSum; map_b = ~b_q; map_cin = cin_q; map_we = 4'b1111; end
            OpCmp: begin map_func = FuncSum; map_b = ~b_q; map_cin = 1'b1;  map_we = 4'b0111; end
            OpAnd: begin map_func = FuncAnd; map_b = b_q;  map_cin = 1'b0;  map_we = 4'b0110; end
            OpOra: begin map_func = FuncOr;  map_b = b_q;  map_cin = 1'b0;  map_we = 4'b0110; end
            OpEor: begin map_func = FuncXor; map_b = b_q;  map_cin = 1'b0;  map_we = 4'b0110; end
            OpAsl: begin map_func = FuncSum; map_b = a_q;  map_cin = 1'b0;  map_we = 4'b0111; end
            OpInc: begin map_func = FuncSum; map_b = '0;   map_cin = 1'b1;  map_we = 4'b0110; end
            OpDec: begin map_func = FuncSum; map_b = '1;   map_cin = 1'b0;  map_we = 4'b0110; end
            default: ;
        endcase
    end

    // Raw {V,N,Z,C} from the ALU outputs; V uses the operands actually presented to the ALU.
    logic       ovf;
    logic [3:0] raw_flags;

    always_comb begin
        ovf       = (alu_a_q[Msb] == alu_b_q[Msb]) && (alu_dout[Msb] != alu_a_q[Msb]);
        raw_flags = {ovf, alu_dout[Msb], (alu_dout == '0), alu_cout};
    end

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_func_d = alu_func_q;
        alu_cin_d  = alu_cin_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        flags_d    = flags_q;
        flag_we_d  = flag_we_q;
        err_d      = err_q;

        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    opc_d = op_code;
                    a_d   = op_a;
                    b_d   = op_b;
                    cin_d = carry_in;
                    if (op_code <= OpDec) begin
                        err_d   = 1'b0;
                        state_d = StFlush;
                    end else begin
                        // Illegal opcode: report immediately, the ALU is never driven.
                        err_d     = 1'b1;
                        result_d  = '0;
                        flags_d   = 4'b0000;
                        flag_we_d = 4'b0000;
                        state_d   = StDone;
                    end
                end
            end
            StFlush: begin
                // alu_func is NOP during this cycle; the mapped drive appears in ISSUE.
                alu_func_d = map_func;
                alu_a_d    = a_q;
                alu_b_d    = map_b;
                alu_cin_d  = map_cin;
                cnt_d      = '0;
                state_d    = StIssue;
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (alu_wout) begin
                    result_d   = (opc_q == OpCmp) ? a_q : alu_dout;
                    flags_d    = raw_flags & map_we;
                    flag_we_d  = map_we;
                    alu_func_d = FuncNop;
                    state_d    = StDone;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    result_d   = '0;
                    flags_d    = 4'b0000;
                    flag_we_d  = 4'b0000;
                    alu_func_d = FuncNop;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                alu_func_d = FuncNop;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            opc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= FuncNop;
            alu_cin_q  <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            flags_q    <= 4'b0000;
            flag_we_q  <= 4'b0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_func_q <= alu_func_d;
            alu_cin_q  <= alu_cin_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            flag_we_q  <= flag_we_d;
            err_q      <= err_d;
        end
    end

    assign op_ready  = (state_q == StIdle);
    assign res_valid = (state_q == StDone);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_func  = alu_func_q;
    assign alu_cin   = alu_cin_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign flag_we   = flag_we_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a small behavioural ALU and a
// result scoreboard. Stimulus pushes the expected response; a monitor pops on each result
// handshake. ALU func encoding assumed: SUM 0, AND 1, OR 2, XOR 3, NOP all ones.

module tb_alu_sequencer;

    localparam logic [3:0] NOP   = 4'hF;
    localparam logic [3:0] F_SUM = 4'h0;
    localparam logic [3:0] F_AND = 4'h1;
    localparam logic [3:0] F_OR  = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    logic       phi1;
    logic       reset_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       carry_in;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_func;
    logic       alu_cin;
    logic [7:0] alu_dout;
    logic       alu_cout;
    logic       alu_wout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] flag_we;
    logic       err;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [3:0] fl;
        logic [3:0] we;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    logic wout_block;

    alu_sequencer #(
        .REG_WIDTH(8),
        .OPP_WIDTH(4),
        .TIMEOUT  (8)
    ) dut (
        .phi1     (phi1),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .carry_in (carry_in),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_func (alu_func),
        .alu_cin  (alu_cin),
        .alu_dout (alu_dout),
        .alu_cout (alu_cout),
        .alu_wout (alu_wout),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .result   (result),
        .flags    (flags),
        .flag_we  (flag_we),
        .err      (err)
    );

    initial begin
        phi1 = 1'b0;
        forever #5 phi1 = ~phi1;
    end

    // Behavioural ALU: one-cycle registered result; wout is high whenever a real func was
    // presented on the previous edge, and can be blocked to provoke the timeout.
    always @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            alu_dout <= 8'h00;
            alu_cout <= 1'b0;
            alu_wout <= 1'b0;
        end else begin
            alu_wout <= (alu_func != NOP) && !wout_block;
            case (alu_func)
                F_SUM: {alu_cout, alu_dout} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
                F_AND: begin alu_dout <= alu_a & alu_b; alu_cout <= 1'b0; end
                F_OR:  begin alu_dout <= alu_a | alu_b; alu_cout <= 1'b0; end
                F_XOR: begin alu_dout <= alu_a ^ alu_b; alu_cout <= 1'b0; end
                default: ;
            endcase
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: one transfer per negedge where the result handshake is complete.
    always @(negedge phi1) begin
        if (reset_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected result: got %0h with no pending expectation", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " result"},  32'(result),  32'(e.res));
                check({e.name, " flags"},   32'(flags),   32'(e.fl));
                check({e.name, " flag_we"}, 32'(flag_we), 32'(e.we));
                check({e.name, " err"},     32'(err),     32'(e.err));
            end
        end
    end

    // Issue one op, check handshake, ALU drive in ISSUE and latency (edges after the accept
    // edge until res_valid). legal=0 skips the ISSUE drive check.
    task automatic do_op(input string name, input logic [3:0] code, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic legal,
                         input logic [3:0] efunc, input logic [7:0] eb, input logic ecin,
                         input logic [7:0] eres, input logic [3:0] efl, input logic [3:0] ewe,
                         input logic eerr, input int elat);
        exp_t e;
        int   lat;
        int   k;
        e.name = name;
        e.res  = eres;
        e.fl   = efl;
        e.we   = ewe;
        e.err  = eerr;
        exp_q.push_back(e);
        @(negedge phi1);
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        carry_in = cin;
        check({name, " op_ready"}, 32'(op_ready), 32'd1);
        @(posedge phi1);
        #1;
        // Scramble inputs so the DUT must use its latched copies.
        op_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        carry_in = ~cin;
        check({name, " flush func"}, 32'(alu_func), 32'(NOP));
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge phi1);
            #1;
            lat++;
            if (lat == 1 && legal) begin
                check({name, " issue func"}, 32'(alu_func), 32'(efunc));
                check({name, " issue a"},    32'(alu_a),    32'(a));
                check({name, " issue b"},    32'(alu_b),    32'(eb));
                check({name, " issue cin"},  32'(alu_cin),  32'(ecin));
            end
        end
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " done func"}, 32'(alu_func), 32'(NOP));
        k = 0;
        while (res_valid && k < 10) begin
            @(posedge phi1);
            #1;
            k++;
        end
        check({name, " res_valid drop"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        op_valid   = 1'b0;
        op_code    = 4'h0;
        op_a       = 8'h00;
        op_b       = 8'h00;
        carry_in   = 1'b0;
        res_ready  = 1'b1;
        wout_block = 1'b0;
        #12;
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset alu_func",  32'(alu_func),  32'(NOP));
        check("reset alu_a",     32'(alu_a),     32'h00);
        check("reset alu_b",     32'(alu_b),     32'h00);
        check("reset alu_cin",   32'(alu_cin),   32'd0);
        check("reset result",    32'(result),    32'h00);
        check("reset flags",     32'(flags),     32'h0);
        check("reset flag_we",   32'(flag_we),   32'h0);
        check("reset err",       32'(err),       32'd0);
        @(negedge phi1);
        reset_n = 1'b1;
        #1;
        check("reset op_ready", 32'(op_ready), 32'd1);

        //    name     code  a      b      cin  legal func   alu_b  cin  res    flags    we       err lat
        do_op("ADC",   4'h0, 8'h50, 8'h50, 1'b0, 1'b1, F_SUM, 8'h50, 1'b0, 8'hA0, 4'b1100, 4'b1111, 1'b0, 3);
        do_op("SBC",   4'h1, 8'h50, 8'hF0, 1'b1, 1'b1, F_SUM, 8'h0F, 1'b1, 8'h60, 4'b0000, 4'b1111, 1'b0, 3);
        do_op("AND1",  4'h2, 8'hF0, 8'h0F, 1'b0, 1'b1, F_AND, 8'h0F, 1'b0, 8'h00, 4'b0010, 4'b0110, 1'b0, 3);
        do_op("AND2",  4'h2, 8'hFF, 8'h3C, 1'b0, 1'b1, F_AND, 8'h3C, 1'b0, 8'h3C, 4'b0000, 4'b0110, 1'b0, 3);
        do_op("CMP",   4'h5, 8'h10, 8'h10, 1'b0, 1'b1, F_SUM, 8'hEF, 1'b1, 8'h10, 4'b0011, 4'b0111, 1'b0, 3);
        do_op("DEC",   4'h8, 8'h00, 8'h55, 1'b1, 1'b1, F_SUM, 8'hFF, 1'b0, 8'hFF, 4'b0100, 4'b0110, 1'b0, 3);
        do_op("ORA",   4'h3, 8'h81, 8'h02, 1'b1, 1'b1, F_OR,  8'h02, 1'b0, 8'h83, 4'b0100, 4'b0110, 1'b0, 3);
        do_op("EOR",   4'h4, 8'hFF, 8'hFF, 1'b0, 1'b1, F_XOR, 8'hFF, 1'b0, 8'h00, 4'b0010, 4'b0110, 1'b0, 3);
        do_op("ASL",   4'h6, 8'hC1, 8'h00, 1'b1, 1'b1, F_SUM, 8'hC1, 1'b0, 8'h82, 4'b0101, 4'b0111, 1'b0, 3);
        do_op("INC",   4'h7, 8'hFF, 8'h12, 1'b0, 1'b1, F_SUM, 8'h00, 1'b1, 8'h00, 4'b0010, 4'b0110, 1'b0, 3);
        do_op("ADCC",  4'h0, 8'hFF, 8'h01, 1'b1, 1'b1, F_SUM, 8'h01, 1'b1, 8'h01, 4'b0001, 4'b1111, 1'b0, 3);

        // Timeout: ISSUE + 8 WAIT cycles with no strobe.
        wout_block = 1'b1;
        do_op("TMO",   4'h0, 8'h12, 8'h34, 1'b0, 1'b1, F_SUM, 8'h34, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1, 10);
        wout_block = 1'b0;

        // Illegal opcode goes straight to DONE on the accept edge.
        do_op("ILL",   4'hC, 8'h77, 8'h88, 1'b1, 1'b0, NOP,   8'h00, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1, 0);

        // Asynchronous reset while parked in WAIT with nobody accepting results.
        res_ready  = 1'b0;
        wout_block = 1'b1;
        @(negedge phi1);
        op_valid = 1'b1;
        op_code  = 4'h0;
        op_a     = 8'h11;
        op_b     = 8'h22;
        carry_in = 1'b0;
        @(posedge phi1);
        #1;
        op_valid = 1'b0;
        repeat (3) @(posedge phi1);
        #3;
        check("pre-reset alu_func", 32'(alu_func), 32'(F_SUM));
        check("pre-reset op_ready", 32'(op_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async reset res_valid", 32'(res_valid), 32'd0);
        check("async reset alu_func",  32'(alu_func),  32'(NOP));
        check("async reset op_ready",  32'(op_ready),  32'd1);
        check("async reset alu_a",     32'(alu_a),     32'h00);
        #2;
        reset_n    = 1'b1;
        wout_block = 1'b0;
        res_ready  = 1'b1;
        do_op("ADC after reset", 4'h0, 8'h01, 8'h01, 1'b0, 1'b1, F_SUM, 8'h01, 1'b0, 8'h02,
              4'b0000, 4'b1111, 1'b0, 3);

        repeat (3) @(posedge phi1);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
